// File: rtl/spi_sample_master.sv
// -----------------------------------------------------------------------------
// spi_sample_master
//   SPI mode-0 bus master (CPOL=0, CPHA=0, MSB first). Each frame sends one
//   command word on MOSI and then clocks in a left/right pair of signed sample
//   words from MISO. The left word is received first. The master is used to
//   bring up the channel-strip SPI responder and as a loopback test source.
//
//   Frame: SETUP (1 tick) -> CMD (2*CMD_W ticks) -> READ (4*DATA_W ticks)
//          -> HOLD (1 tick) -> GAP (2 ticks, CS high) -> IDLE.
//   A tick is CLK_DIV clk_48 cycles, so one tick is one SCLK half-period.
//
// Optional feature (macro SPI_SAMPLE_MASTER_AUTO_EN):
//   adds input auto_run. While it is high, IDLE starts a new frame with the
//   current cmd without waiting for start. start keeps working.
//
// Ports
//   clk_48    in   system clock, the only clock domain
//   reset_n   in   asynchronous active-low reset
//   start     in   single-cycle frame request, sampled only in IDLE
//   cmd       in   command word, captured when start is accepted
//   auto_run  in   continuous frame request (only with the macro defined)
//   busy      out  high from the cycle after acceptance through the end of GAP
//   done      out  one-cycle pulse on the cycle CS rises
//   left_out  out  last complete left sample
//   right_out out  last complete right sample
//   SCLK      out  serial clock, idles low
//   CS        out  chip select, active low, idles high
//   MOSI      out  master data out
//   MISO      in   slave data in
// -----------------------------------------------------------------------------
module spi_sample_master #(
  parameter int CLK_DIV = 4,   // SCLK half-period in clk_48 cycles (1..255)
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 16
) (
  input  logic              clk_48,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd,
`ifdef SPI_SAMPLE_MASTER_AUTO_EN
  input  logic              auto_run,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              SCLK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int          RX_W    = 2 * DATA_W;
  localparam int          BIT_W   = $clog2(RX_W + CMD_W) + 1;
  localparam logic [7:0]  HP_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_READ, S_HOLD, S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          hp_q, hp_d;      // half-period counter
  logic [BIT_W-1:0]    bit_q, bit_d;    // bit count in CMD/READ, tick count in GAP
  logic [CMD_W-1:0]    sr_q, sr_d;      // command shift register
  logic [RX_W-1:0]     rx_q, rx_d;      // receive shift register, left word on top
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   left_q, left_d;
  logic [DATA_W-1:0]   right_q, right_d;

  logic tick;
  logic go;

  assign tick = (hp_q == HP_LAST);

`ifdef SPI_SAMPLE_MASTER_AUTO_EN
  assign go = start | auto_run;
`else
  assign go = start;
`endif

  // NOTE: every variable gets a default before the case statement; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    hp_d    = tick ? 8'd0 : hp_q + 8'd1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    left_d  = left_q;
    right_d = right_q;

    unique case (state_q)
      S_IDLE: begin
        // The counters are held at zero so SETUP starts with a full tick.
        hp_d  = 8'd0;
        bit_d = '0;
        if (go) begin
          sr_d    = cmd;
          mosi_d  = cmd[CMD_W-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (tick) state_d = S_CMD;
      end

      S_CMD: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: present the next command bit, or release MOSI
            // after the last one.
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(CMD_W - 1)) begin
              mosi_d  = 1'b0;
              bit_d   = '0;
              state_d = S_READ;
            end else begin
              sr_d   = sr_q << 1;
              mosi_d = sr_d[CMD_W-1];
              bit_d  = bit_q + BIT_W'(1);
            end
          end
        end
      end

      S_READ: begin
        if (tick) begin
          if (!sclk_q) begin
            // MISO was set up by the slave on the previous falling edge.
            sclk_d = 1'b1;
            rx_d   = {rx_q[RX_W-2:0], MISO};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(RX_W - 1)) begin
              bit_d   = '0;
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
      end

      S_HOLD: begin
        if (tick) begin
          // Sample outputs only ever change here, so they never show a
          // partially shifted pair.
          cs_d    = 1'b1;
          done_d  = 1'b1;
          left_d  = rx_q[RX_W-1:DATA_W];
          right_d = rx_q[DATA_W-1:0];
          bit_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (tick) begin
          if (bit_q == BIT_W'(1)) begin
            busy_d  = 1'b0;
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge. Every register, including the sample words, is reset
  // so an aborted frame leaves the bus idle and the outputs at zero.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hp_q    <= 8'd0;
      bit_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign SCLK      = sclk_q;
  assign CS        = cs_q;
  assign MOSI      = mosi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign left_out  = left_q;
  assign right_out = right_q;

endmodule

// File: tb/tb_spi_sample_master.sv
// -----------------------------------------------------------------------------
// tb_spi_sample_master
//   Directed bench for spi_sample_master. Instance a uses CLK_DIV=4 and
//   instance b uses CLK_DIV=1. Each instance has a mode-0 slave model that
//   shifts a 32-bit word (left word on top) out on MISO after the 8 command
//   bits and records the MOSI bits seen at SCLK rising edges.
// -----------------------------------------------------------------------------
module tb_spi_sample_master;

  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a (CLK_DIV=4)
  logic        start_a = 1'b0;
  logic [7:0]  cmd_a = 8'h00;
  logic        busy_a, done_a, sclk_a, cs_a, mosi_a;
  logic        miso_a = 1'b0;
  logic [15:0] left_a, right_a;
  logic        auto_a = 1'b0;

  // Instance b (CLK_DIV=1)
  logic        start_b = 1'b0;
  logic [7:0]  cmd_b = 8'h00;
  logic        busy_b, done_b, sclk_b, cs_b, mosi_b;
  logic        miso_b = 1'b0;
  logic [15:0] left_b, right_b;

  spi_sample_master #(.CLK_DIV(4), .CMD_W(8), .DATA_W(16)) u_dut_a (
    .clk_48(clk), .reset_n(reset_n), .start(start_a), .cmd(cmd_a),
`ifdef SPI_SAMPLE_MASTER_AUTO_EN
    .auto_run(auto_a),
`endif
    .busy(busy_a), .done(done_a), .left_out(left_a), .right_out(right_a),
    .SCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_sample_master #(.CLK_DIV(1), .CMD_W(8), .DATA_W(16)) u_dut_b (
    .clk_48(clk), .reset_n(reset_n), .start(start_b), .cmd(cmd_b),
`ifdef SPI_SAMPLE_MASTER_AUTO_EN
    .auto_run(1'b0),
`endif
    .busy(busy_b), .done(done_b), .left_out(left_b), .right_out(right_b),
    .SCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b)
  );

  // ---------------------------------------------------------------------------
  // Slave models and bus monitors, sampled on the falling clk edge.
  // ---------------------------------------------------------------------------
  logic [31:0] word_a = 32'h0, word_b = 32'h0;
  logic [7:0]  mosi_bits_a = 8'h0, mosi_bits_b = 8'h0;
  int rises_a = 0, falls_a = 0, cs_low_a = 0, hi_a = 0, gap_a = 0;
  int frames_a = 0, done_cnt_a = 0;
  int rises_b = 0, falls_b = 0, cs_low_b = 0, hi_b = 0, gap_b = 0;
  int frames_b = 0, done_cnt_b = 0;
  logic prv_cs_a = 1'b1, prv_sclk_a = 1'b0;
  logic prv_cs_b = 1'b1, prv_sclk_b = 1'b0;

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (prv_cs_a && cs_a === 1'b0) begin
      frames_a++; gap_a = hi_a; cs_low_a = 0; rises_a = 0; falls_a = 0;
      mosi_bits_a = 8'h0; miso_a = 1'b0;
    end
    if (cs_a === 1'b0) begin cs_low_a++; hi_a = 0; end else hi_a++;
    if (sclk_a === 1'b1 && !prv_sclk_a) begin
      rises_a++;
      if (rises_a <= 8) mosi_bits_a = {mosi_bits_a[6:0], mosi_a};
    end
    if (sclk_a === 1'b0 && prv_sclk_a) begin
      falls_a++;
      if (falls_a >= 8 && falls_a < 40) miso_a = word_a[39 - falls_a];
    end
    prv_cs_a   = (cs_a !== 1'b0);
    prv_sclk_a = (sclk_a === 1'b1);
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) done_cnt_b++;
    if (prv_cs_b && cs_b === 1'b0) begin
      frames_b++; gap_b = hi_b; cs_low_b = 0; rises_b = 0; falls_b = 0;
      mosi_bits_b = 8'h0; miso_b = 1'b0;
    end
    if (cs_b === 1'b0) begin cs_low_b++; hi_b = 0; end else hi_b++;
    if (sclk_b === 1'b1 && !prv_sclk_b) begin
      rises_b++;
      if (rises_b <= 8) mosi_bits_b = {mosi_bits_b[6:0], mosi_b};
    end
    if (sclk_b === 1'b0 && prv_sclk_b) begin
      falls_b++;
      if (falls_b >= 8 && falls_b < 40) miso_b = word_b[39 - falls_b];
    end
    prv_cs_b   = (cs_b !== 1'b0);
    prv_sclk_b = (sclk_b === 1'b1);
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: request a frame for one cycle.
  task automatic pulse_a(input logic [7:0] c);
    start_a = 1'b1; cmd_a = c;
    @(negedge clk);
    start_a = 1'b0; cmd_a = 8'hEE;   // later cmd changes must be ignored
  endtask

  task automatic pulse_b(input logic [7:0] c);
    start_b = 1'b1; cmd_b = c;
    @(negedge clk);
    start_b = 1'b0; cmd_b = 8'hEE;
  endtask

  // Cycles from the cycle after acceptance (t=1) to the done cycle.
  task automatic wait_done_a(input string tag, output int t);
    t = 1;
    while (done_a !== 1'b1 && t < LIMIT) begin @(negedge clk); t++; end
    if (t >= LIMIT) check({tag, "_timeout"}, 64'(t), 64'(0));
  endtask

  task automatic wait_done_b(input string tag, output int t);
    t = 1;
    while (done_b !== 1'b1 && t < LIMIT) begin @(negedge clk); t++; end
    if (t >= LIMIT) check({tag, "_timeout"}, 64'(t), 64'(0));
  endtask

  task automatic wait_idle_a(input string tag, output int t);
    t = 0;
    while (busy_a !== 1'b0 && t < LIMIT) begin @(negedge clk); t++; end
    if (t >= LIMIT) check({tag, "_timeout"}, 64'(t), 64'(0));
  endtask

  task automatic wait_idle_b(input string tag, output int t);
    t = 0;
    while (busy_b !== 1'b0 && t < LIMIT) begin @(negedge clk); t++; end
    if (t >= LIMIT) check({tag, "_timeout"}, 64'(t), 64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t, t2, d0, f0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs",    cs_a,    1'b1);
    check("rst_sclk",  sclk_a,  1'b0);
    check("rst_mosi",  mosi_a,  1'b0);
    check("rst_busy",  busy_a,  1'b0);
    check("rst_done",  done_a,  1'b0);
    check("rst_left",  left_a,  16'h0);
    check("rst_right", right_a, 16'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: cmd 0x01, slave 0x0001 / 0xFFFF
    word_a = 32'h0001_FFFF;
    pulse_a(8'h01);
    check("t1_busy_after_accept", busy_a, 1'b1);
    check("t1_cs_after_accept",   cs_a,   1'b0);
    wait_done_a("t1_done", t);
    check("t1_start_to_done", 64'(t), 64'd329);
    check("t1_cs_low_cycles", 64'(cs_low_a), 64'd328);
    check("t1_mosi_bits", mosi_bits_a, 8'h01);
    check("t1_left",  left_a,  16'h0001);
    check("t1_right", right_a, 16'hFFFF);
    check("t1_cs_at_done", cs_a, 1'b1);
    check("t1_busy_at_done", busy_a, 1'b1);
    wait_idle_a("t1_idle", t2);
    check("t1_done_to_idle", 64'(t2), 64'd8);

    // T2: cmd 0xA5, slave 0x8000 / 0x7FFF
    word_a = 32'h8000_7FFF;
    pulse_a(8'hA5);
    wait_done_a("t2_done", t);
    check("t2_mosi_bits", mosi_bits_a, 8'hA5);
    check("t2_sclk_rises", 64'(rises_a), 64'd40);
    check("t2_left",  left_a,  16'h8000);
    check("t2_right", right_a, 16'h7FFF);
    wait_idle_a("t2_idle", t2);

    // T3: start again 100 cycles into the frame is ignored
    word_a = 32'h1357_2468;
    d0 = done_cnt_a; f0 = frames_a;
    pulse_a(8'h5A);
    repeat (99) @(negedge clk);
    pulse_a(8'hC3);
    check("t3_busy_during_frame", busy_a, 1'b1);
    wait_done_a("t3_done", t);
    check("t3_mosi_bits", mosi_bits_a, 8'h5A);
    repeat (600) @(negedge clk);
    check("t3_done_pulses", 64'(done_cnt_a - d0), 64'd1);
    check("t3_frames", 64'(frames_a - f0), 64'd1);
    check("t3_busy_after", busy_a, 1'b0);
    check("t3_left",  left_a,  16'h1357);
    check("t3_right", right_a, 16'h2468);

    // T4: reset 200 cycles into the frame aborts it
    word_a = 32'hDEAD_BEEF;
    d0 = done_cnt_a;
    pulse_a(8'h77);
    repeat (199) @(negedge clk);
    check("t4_busy_before_reset", busy_a, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t4_cs",    cs_a,    1'b1);
    check("t4_sclk",  sclk_a,  1'b0);
    check("t4_mosi",  mosi_a,  1'b0);
    check("t4_busy",  busy_a,  1'b0);
    check("t4_left",  left_a,  16'h0);
    check("t4_right", right_a, 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    check("t4_no_done", 64'(done_cnt_a - d0), 64'd0);
    word_a = 32'h1234_5678;
    pulse_a(8'h3C);
    wait_done_a("t4_clean_done", t);
    check("t4_clean_start_to_done", 64'(t), 64'd329);
    check("t4_clean_mosi", mosi_bits_a, 8'h3C);
    check("t4_clean_left",  left_a,  16'h1234);
    check("t4_clean_right", right_a, 16'h5678);
    wait_idle_a("t4_idle", t2);

    // T5: CLK_DIV=1, two back-to-back frames
    word_b = 32'hA5A5_0F0F;
    pulse_b(8'h81);
    wait_done_b("t5a_done", t);
    check("t5a_start_to_done", 64'(t), 64'd83);
    check("t5a_cs_low", 64'(cs_low_b), 64'd82);
    check("t5a_rises", 64'(rises_b), 64'd40);
    check("t5a_mosi", mosi_bits_b, 8'h81);
    check("t5a_left",  left_b,  16'hA5A5);
    check("t5a_right", right_b, 16'h0F0F);
    word_b = 32'hFEDC_0123;
    wait_idle_b("t5a_idle", t2);
    check("t5a_done_to_idle", 64'(t2), 64'd2);
    pulse_b(8'h42);
    wait_done_b("t5b_done", t);
    check("t5b_gap", 64'(gap_b), 64'd3);
    check("t5b_cs_low", 64'(cs_low_b), 64'd82);
    check("t5b_rises", 64'(rises_b), 64'd40);
    check("t5b_mosi", mosi_bits_b, 8'h42);
    check("t5b_left",  left_b,  16'hFEDC);
    check("t5b_right", right_b, 16'h0123);
    wait_idle_b("t5b_idle", t2);

`ifdef SPI_SAMPLE_MASTER_AUTO_EN
    // T6: auto_run streams frames separated by the GAP time only
    d0 = done_cnt_a; f0 = frames_a;
    word_a = 32'h0001_0002;
    cmd_a  = 8'h99;
    auto_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        // Third frame has started: drop auto_run so the stream stops after it.
        t2 = 0;
        while (cs_a !== 1'b0 && t2 < LIMIT) begin @(negedge clk); t2++; end
        auto_a = 1'b0;
      end
      wait_done_a("t6_done", t);
      check("t6_left",  left_a,  16'(32'h0001 + k));
      check("t6_right", right_a, 16'(32'h0002 + k));
      word_a = word_a + 32'h0001_0001;
      if (k > 0) check("t6_gap", 64'(gap_a), 64'd9);
      @(negedge clk);
    end
    repeat (600) @(negedge clk);
    check("t6_done_pulses", 64'(done_cnt_a - d0), 64'd3);
    check("t6_frames", 64'(frames_a - f0), 64'd3);
    check("t6_busy_after", busy_a, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
